// File: rtl/vid_tpg_16b.sv
`default_nettype none
// ============================================================================
// Module      : vid_tpg_16b
// Description : Video timing and colour-bar test-pattern generator (YUV 4:2:2).
//               Optional luma ramp pattern enabled by macro VID_TPG_RAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vid_tpg_16b #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36
) (
    input  logic        vclk,
    input  logic        resetn,
    input  logic        enable,
`ifdef VID_TPG_RAMP_EN
    input  logic        pattern_sel,
`endif
    output logic        vid_vblank,
    output logic        vid_vsync,
    output logic        vid_hblank,
    output logic        vid_hsync,
    output logic        vid_active_video,
    output logic [15:0] vid_data,
    output logic        field_id,
    output logic        frame_start
);
    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hw      = $clog2(c_h_total);
    localparam int c_vw      = $clog2(c_v_total);
    localparam int c_bar_w   = H_ACTIVE / 8;
    localparam int c_bw      = (c_bar_w > 1) ? $clog2(c_bar_w) : 1;

    localparam logic [c_hw-1:0] c_h_last     = c_hw'(c_h_total - 1);
    localparam logic [c_vw-1:0] c_v_last     = c_vw'(c_v_total - 1);
    localparam logic [c_bw-1:0] c_bar_last   = c_bw'(c_bar_w - 1);
    localparam logic [15:0]     c_blank_data = 16'h8010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_cnt_en;
    logic [c_hw-1:0] r_h_cnt;
    logic [c_vw-1:0] r_v_cnt;
    logic [c_bw-1:0] r_bar_px;
    logic [2:0]      r_bar_idx;

    logic            w_h_wrap;
    logic            w_frame_end;
    logic            w_first_px;
    logic            w_hblank;
    logic            w_vblank;
    logic            w_hsync;
    logic            w_vsync;
    logic            w_ramp;
    logic [7:0]      w_y;
    logic [7:0]      w_cb;
    logic [7:0]      w_cr;
    logic [7:0]      w_ramp_y;
    logic [15:0]     w_pixel;
    int              w_h;
    int              w_v;

    assign w_h         = int'(r_h_cnt);
    assign w_v         = int'(r_v_cnt);
    assign w_h_wrap    = (r_h_cnt == c_h_last);
    assign w_frame_end = r_cnt_en && w_h_wrap && (r_v_cnt == c_v_last);
    assign w_first_px  = (r_h_cnt == '0) && (r_v_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (enable) w_state_nxt = ST_RUN;
            ST_RUN:  if (!enable) w_state_nxt = ST_STOP;
            ST_STOP: begin
                if (enable)
                    w_state_nxt = ST_RUN;
                else if (w_frame_end)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counting starts one cycle after leaving IDLE so the first pixel lands two edges after enable.
    always_ff @(posedge vclk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_cnt_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt_en <= (r_state != ST_IDLE) && (w_state_nxt != ST_IDLE);
        end
    end

    always_ff @(posedge vclk or negedge resetn) begin
        if (!resetn) begin
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_bar_px  <= '0;
            r_bar_idx <= 3'd0;
        end else if (!r_cnt_en) begin
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_bar_px  <= '0;
            r_bar_idx <= 3'd0;
        end else if (w_h_wrap) begin
            r_h_cnt   <= '0;
            r_bar_px  <= '0;
            r_bar_idx <= 3'd0;
            r_v_cnt   <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
            if (r_bar_px == c_bar_last) begin
                r_bar_px <= '0;
                if (r_bar_idx != 3'd7)
                    r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_px <= r_bar_px + 1'b1;
            end
        end
    end

    assign w_hblank = (w_h >= H_ACTIVE);
    assign w_vblank = (w_v >= V_ACTIVE);
    assign w_hsync  = (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC);
    assign w_vsync  = (w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC);

    always_comb begin
        w_y  = 8'd16;
        w_cb = 8'd128;
        w_cr = 8'd128;
        case (r_bar_idx)
            3'd0: begin w_y = 8'd235; w_cb = 8'd128; w_cr = 8'd128; end
            3'd1: begin w_y = 8'd210; w_cb = 8'd16;  w_cr = 8'd146; end
            3'd2: begin w_y = 8'd170; w_cb = 8'd166; w_cr = 8'd16;  end
            3'd3: begin w_y = 8'd145; w_cb = 8'd54;  w_cr = 8'd34;  end
            3'd4: begin w_y = 8'd106; w_cb = 8'd202; w_cr = 8'd222; end
            3'd5: begin w_y = 8'd81;  w_cb = 8'd90;  w_cr = 8'd240; end
            3'd6: begin w_y = 8'd41;  w_cb = 8'd240; w_cr = 8'd110; end
            default: begin w_y = 8'd16; w_cb = 8'd128; w_cr = 8'd128; end
        endcase
    end

`ifdef VID_TPG_RAMP_EN
    // Pattern choice is latched on the first pixel and used for the whole frame.
    logic r_ramp;

    always_comb w_ramp = w_first_px ? pattern_sel : r_ramp;

    always_ff @(posedge vclk or negedge resetn) begin
        if (!resetn)
            r_ramp <= 1'b0;
        else if (r_cnt_en && w_first_px)
            r_ramp <= pattern_sel;
    end
`else
    assign w_ramp = 1'b0;
`endif

    assign w_ramp_y = 8'(r_h_cnt);
    assign w_pixel  = w_ramp ? {8'd128, w_ramp_y} : {(r_h_cnt[0] ? w_cr : w_cb), w_y};

    always_ff @(posedge vclk or negedge resetn) begin
        if (!resetn) begin
            vid_vblank       <= 1'b1;
            vid_vsync        <= 1'b0;
            vid_hblank       <= 1'b1;
            vid_hsync        <= 1'b0;
            vid_active_video <= 1'b0;
            vid_data         <= c_blank_data;
            frame_start      <= 1'b0;
        end else if (!r_cnt_en) begin
            vid_vblank       <= 1'b1;
            vid_vsync        <= 1'b0;
            vid_hblank       <= 1'b1;
            vid_hsync        <= 1'b0;
            vid_active_video <= 1'b0;
            vid_data         <= c_blank_data;
            frame_start      <= 1'b0;
        end else begin
            vid_vblank       <= w_vblank;
            vid_vsync        <= w_vsync;
            vid_hblank       <= w_hblank;
            vid_hsync        <= w_hsync;
            vid_active_video <= !w_hblank && !w_vblank;
            vid_data         <= (!w_hblank && !w_vblank) ? w_pixel : c_blank_data;
            frame_start      <= w_first_px;
        end
    end

    assign field_id = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vid_tpg_16b.sv
`default_nettype none
// ============================================================================
// Module      : tb_vid_tpg_16b
// Description : Scoreboard bench for vid_tpg_16b on a reduced 24x8 raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vid_tpg_16b;
    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 2;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 1;
    localparam int V_BP     = 2;
    localparam int H_TOTAL  = 24;
    localparam int FRAME    = 192;

    // {vblank, vsync, hblank, hsync, active, frame_start, field_id, data}
    localparam logic [22:0] IDLE_VEC = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8010};

    logic        vclk;
    logic        resetn;
    logic        enable;
    logic        vid_vblank;
    logic        vid_vsync;
    logic        vid_hblank;
    logic        vid_hsync;
    logic        vid_active_video;
    logic [15:0] vid_data;
    logic        field_id;
    logic        frame_start;
`ifdef VID_TPG_RAMP_EN
    logic        pattern_sel;
`endif

    logic [22:0] exp_q[$];
    int          errors;
    int          checks;

    vid_tpg_16b #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .vclk             (vclk),
        .resetn           (resetn),
        .enable           (enable),
`ifdef VID_TPG_RAMP_EN
        .pattern_sel      (pattern_sel),
`endif
        .vid_vblank       (vid_vblank),
        .vid_vsync        (vid_vsync),
        .vid_hblank       (vid_hblank),
        .vid_hsync        (vid_hsync),
        .vid_active_video (vid_active_video),
        .vid_data         (vid_data),
        .field_id         (field_id),
        .frame_start      (frame_start)
    );

    initial begin
        vclk = 1'b0;
        forever #5 vclk = ~vclk;
    end

    // Expected bus for raster position k (0..191) of a frame.
    function automatic logic [22:0] model_pix(input int k);
        int         h;
        int         v;
        int         bar;
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic       hb;
        logic       vb;
        logic       act;
        logic [15:0] d;
        h   = k % H_TOTAL;
        v   = k / H_TOTAL;
        hb  = (h >= 16);
        vb  = (v >= 4);
        act = !hb && !vb;
        bar = h / 2;
        if (bar > 7) bar = 7;
        case (bar)
            0: begin y = 235; cb = 128; cr = 128; end
            1: begin y = 210; cb = 16;  cr = 146; end
            2: begin y = 170; cb = 166; cr = 16;  end
            3: begin y = 145; cb = 54;  cr = 34;  end
            4: begin y = 106; cb = 202; cr = 222; end
            5: begin y = 81;  cb = 90;  cr = 240; end
            6: begin y = 41;  cb = 240; cr = 110; end
            default: begin y = 16; cb = 128; cr = 128; end
        endcase
        d = act ? {((h % 2) == 1 ? cr : cb), y} : 16'h8010;
        return {vb, (v == 5), hb, (h >= 18 && h < 20), act, (h == 0 && v == 0), 1'b0, d};
    endfunction

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(IDLE_VEC);
    endtask

    task automatic push_pix(input int first, input int last);
        for (int k = first; k <= last; k++) exp_q.push_back(model_pix(k));
    endtask

    task automatic compare_one(input string tag, input int idx);
        logic [22:0] obs;
        logic [22:0] expv;
        obs = {vid_vblank, vid_vsync, vid_hblank, vid_hsync, vid_active_video,
               frame_start, field_id, vid_data};
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s[%0d]: scoreboard empty, observed=%h", tag, idx, obs);
        end else begin
            expv = exp_q.pop_front();
            checks++;
            assert (obs === expv) else begin
                errors++;
                $error("FAIL %s[%0d]: observed=%h expected=%h", tag, idx, obs, expv);
            end
        end
    endtask

    task automatic check_n(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge vclk);
            compare_one(tag, i);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        resetn = 1'b1;
        enable = 1'b0;
`ifdef VID_TPG_RAMP_EN
        pattern_sel = 1'b0;
`endif
        #3 resetn = 1'b0;
        repeat (3) @(negedge vclk);

        // Reset values, then idle with enable low after release
        push_idle(2);
        check_n(2, "reset");
        resetn = 1'b1;
        push_idle(2);
        check_n(2, "idle");

        // Start: two idle samples, one full frame, then into line 1 of the next
        enable = 1'b1;
        push_idle(2);
        push_pix(0, FRAME - 1);
        push_pix(0, 29);
        check_n(2 + FRAME + 30, "run");

        // Drop enable at v_cnt=1: frame completes, then no further frame_start
        enable = 1'b0;
        push_pix(30, FRAME - 1);
        push_idle(30);
        check_n(FRAME - 30 + 30, "stop_drain");

        // Drop and restore during STOP: frames stay contiguous
        enable = 1'b1;
        push_idle(2);
        push_pix(0, FRAME - 1);
        push_pix(0, 99);
        check_n(2 + FRAME + 100, "run2");
        enable = 1'b0;
        push_pix(100, 149);
        check_n(50, "stop_mid");
        enable = 1'b1;
        push_pix(150, FRAME - 1);
        push_pix(0, FRAME - 1);
        push_pix(0, 29);
        check_n(FRAME - 150 + FRAME + 30, "resume");

        // Asynchronous reset mid-line, checked before the next clock edge
        #2 resetn = 1'b0;
        #1;
        push_idle(1);
        compare_one("async_reset", 0);
        push_idle(2);
        check_n(2, "in_reset");
        resetn = 1'b1;
        push_idle(2);
        push_pix(0, FRAME - 1);
        check_n(2 + FRAME, "post_reset");

        // Enable dropped on a frame boundary still yields one whole frame
        enable = 1'b0;
        push_pix(0, FRAME - 1);
        push_idle(5);
        check_n(FRAME + 5, "final_frame");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
